// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit ripple segment per stage,
// carry registered between stages, valid/ready handshake on both sides.
module rca_pipe #(
  parameter int N   = 32,
  parameter int SEG = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         C_in,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] S_out,
  output logic         C_out,
  output logic         ovf
);

  localparam int STAGES = N / SEG;

  // Stage registers; operands carry the unprocessed upper segments forward,
  // the sum carries the finished lower segments forward.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [N-1:0]      a_q [STAGES];
  logic [N-1:0]      b_q [STAGES];
  logic [N-1:0]      s_q [STAGES];
  logic              c_msb_q;

  // Per-stage inputs (from the port for stage 0, from stage k-1 otherwise).
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [N-1:0]      a_src [STAGES];
  logic [N-1:0]      b_src [STAGES];
  logic [N-1:0]      s_src [STAGES];

  // Per-stage next values.
  logic [N-1:0]      s_d [STAGES];
  logic [STAGES-1:0] c_d;
  logic [STAGES-1:0] stage_ready;
  logic              c_msb_d;

  always_comb begin
    logic [STAGES-1:0] low_mask;
    logic [SEG:0]      seg_sum;

    v_src    = '0;
    c_src    = '0;
    c_d      = '0;
    low_mask = '0;
    seg_sum  = '0;

    v_src[0] = in_valid;
    c_src[0] = sub ? ~C_in : C_in;
    a_src[0] = A;
    b_src[0] = sub ? ~B : B;
    s_src[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      v_src[k] = v_q[k-1];
      c_src[k] = c_q[k-1];
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      seg_sum  = {1'b0, a_src[k][k*SEG +: SEG]} + {1'b0, b_src[k][k*SEG +: SEG]}
               + {{SEG{1'b0}}, c_src[k]};
      s_d[k]   = s_src[k];
      s_d[k][k*SEG +: SEG] = seg_sum[SEG-1:0];
      c_d[k]   = seg_sum[SEG];

      // NOTE: ready_k = !v_k || ready_{k+1} unrolls to "out_ready or any stage
      // at or after k is empty"; writing it that way avoids a self-referencing vector.
      low_mask       = (STAGES'(1) << k) - STAGES'(1);
      stage_ready[k] = out_ready || !(&(v_q | low_mask));
    end

    // Carry into the MSB recovered from the MSB's own sum bit.
    c_msb_d = a_src[STAGES-1][N-1] ^ b_src[STAGES-1][N-1] ^ s_d[STAGES-1][N-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well as the valid bits, so the
      // outputs read zero after reset rather than stale or X values.
      v_q     <= '0;
      c_q     <= '0;
      c_msb_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (stage_ready[k]) begin
          v_q[k] <= v_src[k];
          if (v_src[k]) begin
            a_q[k] <= a_src[k];
            b_q[k] <= b_src[k];
            s_q[k] <= s_d[k];
            c_q[k] <= c_d[k];
          end
        end
      end
      if (stage_ready[STAGES-1] && v_src[STAGES-1]) c_msb_q <= c_msb_d;
    end
  end

  assign in_ready  = stage_ready[0];
  assign out_valid = v_q[STAGES-1];
  assign S_out     = s_q[STAGES-1];
  assign C_out     = c_q[STAGES-1];
  assign ovf       = c_msb_q ^ c_q[STAGES-1];

endmodule

// File: tb/tb_rca_pipe.sv
// Bench for rca_pipe: three instances (SEG = 8, 1, 32 at N = 32) driven by
// directed vectors, streaming/backpressure sequences and randomized traffic.
module tb_rca_pipe;

  localparam int NI = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NI-1:0]   iv, ir, ov, ordy, ci, sb, co, of;
  logic [31:0]     a [NI];
  logic [31:0]     b [NI];
  logic [31:0]     s [NI];
  int              stg [NI];

  always #5 clk = ~clk;

  rca_pipe #(.N(32), .SEG(8)) u_seg8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .A(a[0]), .B(b[0]),
    .C_in(ci[0]), .sub(sb[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .S_out(s[0]),
    .C_out(co[0]), .ovf(of[0]));

  rca_pipe #(.N(32), .SEG(1)) u_seg1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .A(a[1]), .B(b[1]),
    .C_in(ci[1]), .sub(sb[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .S_out(s[1]),
    .C_out(co[1]), .ovf(of[1]));

  rca_pipe #(.N(32), .SEG(32)) u_seg32 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .A(a[2]), .B(b[2]),
    .C_in(ci[2]), .sub(sb[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .S_out(s[2]),
    .C_out(co[2]), .ovf(of[2]));

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        ci;
    logic        sb;
    logic [31:0] s;
    logic        c;
    logic        v;
  } vec_t;

  vec_t        tbl [7];
  logic [33:0] exp_q [$];
  int          total = 0;
  int          bad   = 0;

  localparam longint MAX_S = 64'sd2147483647;
  localparam longint MIN_S = -64'sd2147483648;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: integer arithmetic on the operands as unsigned and as signed.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic is_sub);
    longint ux, uy, sx, sy, r, sr, cl;
    logic   cout, ovfl;
    ux = longint'(x);
    uy = longint'(y);
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    cl = c ? 64'sd1 : 64'sd0;
    if (!is_sub) begin
      r    = ux + uy + cl;
      sr   = sx + sy + cl;
      cout = (r >= 64'sh1_0000_0000);
    end else begin
      r    = ux - uy - cl;
      sr   = sx - sy - cl;
      cout = (ux >= uy + cl);
    end
    ovfl = (sr > MAX_S) || (sr < MIN_S);
    return {ovfl, cout, r[31:0]};
  endfunction

  task automatic send_vec(input int inst, input vec_t t, input bit chk_zero);
    int lat;
    a[inst] = t.a; b[inst] = t.b; ci[inst] = t.ci; sb[inst] = t.sb;
    iv[inst] = 1'b1; ordy[inst] = 1'b1;
    @(negedge clk);
    check("vec_in_ready", 64'(ir[inst]), 64'd1);
    @(posedge clk); #1;
    iv[inst] = 1'b0;
    lat = 1;
    while (lat <= 40) begin
      @(negedge clk);
      if (ov[inst]) break;
      if (chk_zero) check("pre_result_zero", 64'({co[inst], of[inst], s[inst]}), 64'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("vec_latency", 64'(lat), 64'(stg[inst]));
    check("vec_S", 64'(s[inst]), 64'(t.s));
    check("vec_C", 64'(co[inst]), 64'(t.c));
    check("vec_ovf", 64'(of[inst]), 64'(t.v));
    @(posedge clk); #1;
  endtask

  task automatic stream(input int inst, input int n, input int pv, input int pr,
                        input int stall_at, input int stall_len, input bit full_rate);
    int          sent, got, cyc, first_in, first_out;
    bit          held, fired;
    logic [31:0] held_s;
    logic [33:0] e;
    sent = 0; got = 0; cyc = 0; first_in = -1; first_out = -1;
    held = 1'b0; held_s = '0;
    exp_q.delete();
    iv[inst] = 1'b0;
    while (got < n && cyc < 20000) begin
      if (!iv[inst] && sent < n && $urandom_range(99) < pv) begin
        a[inst]  = $urandom;
        b[inst]  = $urandom;
        ci[inst] = 1'($urandom);
        sb[inst] = 1'($urandom);
        iv[inst] = 1'b1;
      end
      if (cyc >= stall_at && cyc < stall_at + stall_len) ordy[inst] = 1'b0;
      else ordy[inst] = ($urandom_range(99) < pr);
      @(negedge clk);
      check("in_ready", 64'(ir[inst]), 64'(ordy[inst] || (exp_q.size() < stg[inst])));
      if (held) check("stall_hold", 64'({ov[inst], s[inst]}), 64'({1'b1, held_s}));
      if (ov[inst] && first_out < 0) first_out = cyc;
      if (ov[inst] && ordy[inst]) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("stream_result", 64'({of[inst], co[inst], s[inst]}), 64'(e));
        end
        got++;
      end
      held   = ov[inst] && !ordy[inst];
      held_s = s[inst];
      fired  = iv[inst] && ir[inst];
      if (fired) begin
        exp_q.push_back(model(a[inst], b[inst], ci[inst], sb[inst]));
        sent++;
        if (first_in < 0) first_in = cyc;
      end
      @(posedge clk); #1;
      if (fired) iv[inst] = 1'b0;
      cyc++;
    end
    iv[inst] = 1'b0;
    ordy[inst] = 1'b1;
    check("stream_count", 64'(got), 64'(n));
    check("first_latency", 64'(first_out - first_in), 64'(stg[inst]));
    if (full_rate) check("no_bubbles", 64'(cyc), 64'(n + stg[inst]));
  endtask

  initial begin
    stg[0] = 4; stg[1] = 32; stg[2] = 1;
    tbl[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    tbl[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0, 32'h0000_0007, 1'b0, 1'b0};
    tbl[4] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    tbl[5] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
    tbl[6] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0};

    rst_n = 1'b0;
    iv = '0; ordy = '1; ci = '0; sb = '0;
    for (int i = 0; i < NI; i++) begin a[i] = '0; b[i] = '0; end
    #12;
    for (int i = 0; i < NI; i++)
      check("reset_outputs", 64'({ov[i], co[i], of[i], s[i]}), 64'd0);
    rst_n = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) check("reset_in_ready", 64'(ir[i]), 64'd1);
    @(posedge clk); #1;

    for (int i = 0; i < NI; i++)
      for (int k = 0; k < 7; k++) send_vec(i, tbl[k], (i == 0 && k == 0));

    stream(0, 100, 100, 100, 1 << 30, 0, 1'b1);
    stream(0, 40, 100, 100, 15, 10, 1'b0);
    for (int i = 0; i < NI; i++) stream(i, 1000, 50, 50, 1 << 30, 0, 1'b0);

    // Asynchronous reset with three transactions in flight.
    ordy[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a[0] = 32'(i + 10); b[0] = 32'(i); ci[0] = 1'b0; sb[0] = 1'b0; iv[0] = 1'b1;
      @(posedge clk); #1;
    end
    iv[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("valid_before_reset", 64'(ov[0]), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_mid_outputs", 64'({ov[0], co[0], of[0], s[0]}), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_empty", 64'(ov[0]), 64'd0);
    send_vec(0, tbl[3], 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
